ysyx_25030077_exit_req: RTL and testbench

Trap-request generator at the commit end of the core: it classifies each committing instruction as ebreak, unknown or normal. On a trap it freezes the pipeline, waits for outstanding LSU traffic to drain, then drives the exit-monitor interface: a one-cycle is_break_out or is_unknown_instruction pulse with the latched io_Pc_count. After that it holds the core halted until reset.

---
 rtl/ysyx_25030077_exit_req_pkg.sv | 40 ++++
 rtl/ysyx_25030077_inst_legal.sv | 53 +++++
 rtl/ysyx_25030077_exit_req.sv | 133 +++++++++++++
 tb/tb_ysyx_25030077_exit_req.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030077_exit_req_pkg.sv
// Shared constants for the commit-end trap-request generator: RV32 opcodes,
// special instruction words, FSM state encoding and trap cause encoding.
package ysyx_25030077_exit_req_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam logic [31:0] ECALL_INST  = 32'h00000073;
  localparam logic [31:0] MRET_INST   = 32'h30200073;

  localparam logic [6:0] FUNCT7_ZERO = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // FSM encoding kept as plain constants so legacy users can compare raw bits.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_FIRE   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BREAK   = 2'd1,
    CAUSE_UNKNOWN = 2'd2
  } cause_e;

  function automatic cause_e trap_cause(input logic is_ebreak);
    return is_ebreak ? CAUSE_BREAK : CAUSE_UNKNOWN;
  endfunction

endpackage

// File: rtl/ysyx_25030077_inst_legal.sv
// Purely combinational RV32I(+Zicsr/mret) legality and ebreak classifier,
// shared between the trap generator and decode.
module ysyx_25030077_inst_legal
  import ysyx_25030077_exit_req_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        legal_o,
  output logic        ebreak_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  assign ebreak_o = (inst_i == EBREAK_INST);

  always_comb begin
    legal_o = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI, OPC_AUIPC, OPC_JAL: legal_o = 1'b1;
        OPC_JALR:     legal_o = (f3 == 3'd0);
        OPC_BRANCH:   legal_o = (f3 != 3'd2) && (f3 != 3'd3);
        OPC_LOAD:     legal_o = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        OPC_STORE:    legal_o = f3 inside {3'd0, 3'd1, 3'd2};
        OPC_OP_IMM: begin
          case (f3)
            3'd1:    legal_o = (f7 == FUNCT7_ZERO);
            3'd5:    legal_o = (f7 == FUNCT7_ZERO) || (f7 == FUNCT7_ALT);
            default: legal_o = 1'b1;
          endcase
        end
        // funct7=0x20 only encodes SUB and SRA
        OPC_OP:       legal_o = (f7 == FUNCT7_ZERO) ||
                                ((f7 == FUNCT7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5)));
        OPC_MISC_MEM: legal_o = 1'b1;
        OPC_SYSTEM: begin
          if (f3 == 3'd0)
            legal_o = (inst_i == ECALL_INST) || (inst_i == EBREAK_INST) ||
                      (inst_i == MRET_INST);
          else
            legal_o = (f3 != 3'd4);
        end
        default:      legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25030077_exit_req.sv
// Commit-end trap-request generator: freezes the core on ebreak/illegal, drains
// the LSU, pulses the exit monitor once, then halts. Optional drain watchdog
// enabled by YSYX_25030077_EXIT_DRAIN_TIMEOUT_EN.
module ysyx_25030077_exit_req
  import ysyx_25030077_exit_req_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic            lsu_busy,
  output logic            stall,
  output logic            is_break_out,
  output logic            is_unknown_instruction,
  output logic [XLEN-1:0] io_Pc_count,
  output logic            drain_timeout
);

  logic [1:0]      state_q, state_d;
  cause_e          cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            stall_q, stall_d;
  logic            brk_q, brk_d;
  logic            unk_q, unk_d;

  logic is_legal;
  logic is_ebreak;
  logic fire;
  logic timeout_hit;

  ysyx_25030077_inst_legal u_inst_legal (
    .inst_i   (inst),
    .legal_o  (is_legal),
    .ebreak_o (is_ebreak)
  );

`ifdef YSYX_25030077_EXIT_DRAIN_TIMEOUT_EN
  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          dto_q;

  // Counter is zero whenever DRAIN is entered because it is held clear in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dto_q <= 1'b0;
    end else begin
      if (state_q == ST_DRAIN)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (timeout_hit)
        dto_q <= 1'b1;
    end
  end

  assign drain_timeout = dto_q;
`else
  assign drain_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    stall_d     = stall_q;
    brk_d       = 1'b0;
    unk_d       = 1'b0;
    fire        = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inst_valid && (is_ebreak || !is_legal)) begin
          cause_d = trap_cause(is_ebreak);
          pc_d    = pc;
          stall_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!lsu_busy) begin
          fire = 1'b1;
        end
`ifdef YSYX_25030077_EXIT_DRAIN_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          fire        = 1'b1;
          timeout_hit = 1'b1;
        end
`endif
        // Flags are registered here so they are high exactly during FIRE.
        if (fire) begin
          state_d = ST_FIRE;
          brk_d   = (cause_q == CAUSE_BREAK) && !timeout_hit;
          unk_d   = (cause_q == CAUSE_UNKNOWN) || timeout_hit;
        end
      end
      ST_FIRE:   state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      pc_q    <= '0;
      stall_q <= 1'b0;
      brk_q   <= 1'b0;
      unk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
      brk_q   <= brk_d;
      unk_q   <= unk_d;
    end
  end

  assign stall                  = stall_q;
  assign is_break_out           = brk_q;
  assign is_unknown_instruction = unk_q;
  assign io_Pc_count            = pc_q;

endmodule

// File: tb/tb_ysyx_25030077_exit_req.sv
// Self-checking bench for ysyx_25030077_exit_req: table of trap/legal vectors
// replayed through a per-cycle expected-output queue, plus corner sequences.
module tb_ysyx_25030077_exit_req;

`ifdef YSYX_25030077_EXIT_DRAIN_TIMEOUT_EN
  localparam int DT = 8;
`else
  localparam int DT = 1024;
`endif

  localparam logic [31:0] EBRK = 32'h00100073;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        lsu_busy;
  logic        stall;
  logic        is_break_out;
  logic        is_unknown_instruction;
  logic [31:0] io_Pc_count;
  logic        drain_timeout;

  ysyx_25030077_exit_req #(
    .XLEN          (32),
    .DRAIN_TIMEOUT (DT)
  ) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .inst_valid             (inst_valid),
    .inst                   (inst),
    .pc                     (pc),
    .lsu_busy               (lsu_busy),
    .stall                  (stall),
    .is_break_out           (is_break_out),
    .is_unknown_instruction (is_unknown_instruction),
    .io_Pc_count            (io_Pc_count),
    .drain_timeout          (drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        brk;
    logic        unk;
    logic        dto;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          busy;
    logic        exp_brk;
    logic        exp_unk;
  } vec_t;

  obs_t exp_q[$];
  int   n_vec;
  int   n_err;
  vec_t vecs[22];

  function automatic obs_t mk(logic s, logic b, logic u, logic d, logic [31:0] p);
    obs_t o;
    o.stall = s; o.brk = b; o.unk = u; o.dto = d; o.pc = p;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string name);
    obs_t a;
    obs_t e;
    @(negedge clk);
    a = mk(stall, is_break_out, is_unknown_instruction, drain_timeout, io_Pc_count);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got stall=%b brk=%b unk=%b dto=%b pc=%h",
               name, a.stall, a.brk, a.unk, a.dto, a.pc);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got stall=%b brk=%b unk=%b dto=%b pc=%h, want stall=%b brk=%b unk=%b dto=%b pc=%h",
                 name, a.stall, a.brk, a.unk, a.dto, a.pc,
                 e.stall, e.brk, e.unk, e.dto, e.pc);
      end
    end
  endtask

  // Leaves the bench just after a reset edge with reset released; checks reset state.
  task automatic do_reset(input string name);
    reset      = 1'b1;
    inst_valid = 1'b0;
    inst       = '0;
    pc         = '0;
    lsu_busy   = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    check_cycle(name);
  endtask

  // Presents one instruction (edge N) then checks cycles N+1.. with lsu_busy
  // held for `busy` cycles after detect.
  task automatic run_vec(input int idx, input vec_t v);
    logic trap;
    obs_t e;
    trap = v.exp_brk || v.exp_unk;
    do_reset($sformatf("vec%0d/reset", idx));
    inst_valid = 1'b1;
    inst       = v.inst;
    pc         = v.pc;
    lsu_busy   = (v.busy > 0);
    for (int k = 1; k <= v.busy + 4; k++) begin
      step();
      inst_valid = 1'b0;
      inst       = '0;
      pc         = 32'hDEADBEEF;
      lsu_busy   = (k <= v.busy);
      if (trap)
        e = mk(1'b1, v.exp_brk && (k == v.busy + 2), v.exp_unk && (k == v.busy + 2),
               1'b0, v.pc);
      else
        e = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(e);
      check_cycle($sformatf("vec%0d/c%0d", idx, k));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    inst_valid = 1'b0;
    inst = '0;
    pc = '0;
    lsu_busy = 1'b0;

    //          inst           pc             busy brk   unk
    vecs[0]  = '{EBRK,         32'h80000010, 0, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000007F, 32'h80000100, 0, 1'b0, 1'b1};
    vecs[2]  = '{EBRK,         32'h80000200, 5, 1'b1, 1'b0};
    vecs[3]  = '{32'h00100093, 32'h80000300, 0, 1'b0, 1'b0}; // addi
    vecs[4]  = '{32'h40000033, 32'h80000304, 0, 1'b0, 1'b0}; // sub
    vecs[5]  = '{32'h40105093, 32'h80000308, 0, 1'b0, 1'b0}; // srai
    vecs[6]  = '{32'h30529073, 32'h8000030C, 0, 1'b0, 1'b0}; // csrrw
    vecs[7]  = '{32'h02000033, 32'h80000400, 0, 1'b0, 1'b1}; // mul
    vecs[8]  = '{32'h00003003, 32'h80000404, 0, 1'b0, 1'b1}; // ld
    vecs[9]  = '{32'h0000001F, 32'h80000408, 0, 1'b0, 1'b1};
    vecs[10] = '{32'h00000073, 32'h80000500, 0, 1'b0, 1'b0}; // ecall
    vecs[11] = '{32'h30200073, 32'h80000504, 0, 1'b0, 1'b0}; // mret
    vecs[12] = '{32'h02001093, 32'h80000508, 0, 1'b0, 1'b1}; // slli bad funct7
    vecs[13] = '{32'h00002063, 32'h8000050C, 0, 1'b0, 1'b1}; // branch f3=2
    vecs[14] = '{32'h00001067, 32'h80000510, 0, 1'b0, 1'b1}; // jalr f3=1
    vecs[15] = '{32'h00003023, 32'h80000514, 0, 1'b0, 1'b1}; // store f3=3
    vecs[16] = '{32'h00002003, 32'h80000518, 0, 1'b0, 1'b0}; // lw
    vecs[17] = '{32'h00004073, 32'h8000051C, 2, 1'b0, 1'b1}; // system f3=4
    vecs[18] = '{32'h001000F3, 32'h80000520, 0, 1'b0, 1'b1}; // ebreak with rd!=0
    vecs[19] = '{32'h00000001, 32'h80000524, 0, 1'b0, 1'b1}; // inst[1:0]!=11
    vecs[20] = '{32'h4000D033, 32'h80000528, 0, 1'b0, 1'b0}; // sra
    vecs[21] = '{32'h40001033, 32'h8000052C, 1, 1'b0, 1'b1}; // sll with funct7=0x20

    for (int i = 0; i < 22; i++)
      run_vec(i, vecs[i]);

    // Second trap while HALTED produces nothing and keeps the first PC.
    do_reset("halt/reset");
    inst_valid = 1'b1; inst = EBRK; pc = 32'h80001000;
    for (int k = 1; k <= 3; k++) begin
      step();
      inst_valid = 1'b0;
      exp_q.push_back(mk(1'b1, k == 2, 1'b0, 1'b0, 32'h80001000));
      check_cycle($sformatf("halt/first c%0d", k));
    end
    inst_valid = 1'b1; inst = 32'h0000007F; pc = 32'h80002000;
    for (int k = 1; k <= 4; k++) begin
      step();
      inst_valid = (k < 2);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h80001000));
      check_cycle($sformatf("halt/second c%0d", k));
    end

    // Reset mid-DRAIN, with a trap offered during reset that must be ignored.
    do_reset("mid/reset");
    inst_valid = 1'b1; inst = EBRK; pc = 32'h80003000; lsu_busy = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      inst_valid = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h80003000));
      check_cycle($sformatf("mid/drain c%0d", k));
    end
    reset = 1'b1; inst_valid = 1'b1; inst = EBRK; pc = 32'h80004000; lsu_busy = 1'b0;
    step();
    reset = 1'b0; inst_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
      check_cycle($sformatf("mid/after c%0d", k));
      step();
    end

    // lsu_busy stuck high: watchdog fires after DT DRAIN cycles, else waits forever.
    do_reset("to/reset");
    inst_valid = 1'b1; inst = EBRK; pc = 32'h80005000; lsu_busy = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      inst_valid = 1'b0;
`ifdef YSYX_25030077_EXIT_DRAIN_TIMEOUT_EN
      exp_q.push_back(mk(1'b1, 1'b0, k == DT + 1, k >= DT + 1, 32'h80005000));
`else
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h80005000));
`endif
      check_cycle($sformatf("to/c%0d", k));
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expected entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
